// File: rtl/ysyx_22050019_axi_rd_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_axi_defs
//   Shared definitions for the two-master AXI4-Lite read arbiter:
//   FSM state encoding, master ids, RRESP codes and the round-robin pick
//   function used by the 2-way picker.
// ----------------------------------------------------------------------------
package ysyx_22050019_axi_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } arb_state_e;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // A lone requester always wins; on contention the master that was not
    // served last wins. With no request the result is unused by the caller.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic id;
        case (req)
            2'b01:   id = M_IFU;
            2'b10:   id = M_LSU;
            default: id = ~last;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/ysyx_22050019_axi_rd_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_rr_arb2
//   Two-way round-robin picker. Holds the last_grant flop, which only moves
//   when the owner (the arbiter top) reports a completed AR handshake.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (last_grant -> M_IFU)
//   i_req[1:0]     : request vector, bit0 = IFU, bit1 = LSU
//   i_last         : id to record as last served
//   i_update       : record i_last this cycle
//   o_gnt_id       : id that would win arbitration now
// ----------------------------------------------------------------------------
module ysyx_22050019_rr_arb2
    import ysyx_22050019_axi_defs::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_update,
    output logic       o_gnt_id
);

    logic r_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= M_IFU;
        end else if (i_update) begin
            r_last <= i_last;
        end
    end

    assign o_gnt_id = rr_pick(i_req, r_last);

endmodule

// File: rtl/ysyx_22050019_axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_axi_rd_arbiter
//   Shares one AXI4-Lite read channel (AR + R) between the IFU (m0) and the
//   LSU (m1). One outstanding transaction; the grant is locked from the
//   IDLE->AR transition until the R handshake completes.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no grant, all outputs 0
//   AR    | granted master's AR forwarded to slave, arready returned
//   R     | slave R forwarded to granted master, rready returned
//
// Ports:
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_m0_* / o_m0_*         : IFU read channel (arvalid/araddr/arready,
//                             rvalid/rready/rdata/rresp)
//   i_m1_* / o_m1_*         : LSU read channel, same set
//   o_s_* / i_s_*           : slave read channel
// ----------------------------------------------------------------------------
module ysyx_22050019_axi_rd_arbiter
    import ysyx_22050019_axi_defs::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              i_m0_arvalid,
    input  logic [ADDR_W-1:0] i_m0_araddr,
    output logic              o_m0_arready,
    output logic              o_m0_rvalid,
    input  logic              i_m0_rready,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic [1:0]        o_m0_rresp,

    input  logic              i_m1_arvalid,
    input  logic [ADDR_W-1:0] i_m1_araddr,
    output logic              o_m1_arready,
    output logic              o_m1_rvalid,
    input  logic              i_m1_rready,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic [1:0]        o_m1_rresp,

    output logic              o_s_arvalid,
    output logic [ADDR_W-1:0] o_s_araddr,
    input  logic              i_s_arready,
    input  logic              i_s_rvalid,
    output logic              o_s_rready,
    input  logic [DATA_W-1:0] i_s_rdata,
    input  logic [1:0]        i_s_rresp
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_gnt_id;
    logic              w_pick_id;
    logic [1:0]        w_req;
    logic              w_g_arvalid;
    logic [ADDR_W-1:0] w_g_araddr;
    logic              w_g_rready;
    logic              w_ar_hs;

    assign w_req       = {i_m1_arvalid, i_m0_arvalid};
    assign w_g_arvalid = (r_gnt_id == M_LSU) ? i_m1_arvalid : i_m0_arvalid;
    assign w_g_araddr  = (r_gnt_id == M_LSU) ? i_m1_araddr  : i_m0_araddr;
    assign w_g_rready  = (r_gnt_id == M_LSU) ? i_m1_rready  : i_m0_rready;
    assign w_ar_hs     = (r_state == ST_AR) && w_g_arvalid && i_s_arready;

    // last_grant moves on the AR handshake, so a master that withdrew its
    // request before the address went out does not lose its turn.
    ysyx_22050019_rr_arb2 u_rr_arb2 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (w_req),
        .i_last   (r_gnt_id),
        .i_update (w_ar_hs),
        .o_gnt_id (w_pick_id)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_gnt_id <= M_IFU;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && (|w_req)) begin
                r_gnt_id <= w_pick_id;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_s_arvalid  = 1'b0;
        o_s_araddr   = '0;
        o_s_rready   = 1'b0;
        o_m0_arready = 1'b0;
        o_m0_rvalid  = 1'b0;
        o_m0_rdata   = '0;
        o_m0_rresp   = RESP_OKAY;
        o_m1_arready = 1'b0;
        o_m1_rvalid  = 1'b0;
        o_m1_rdata   = '0;
        o_m1_rresp   = RESP_OKAY;

        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_state_nxt = ST_AR;
                end
            end
            ST_AR: begin
                o_s_arvalid = w_g_arvalid;
                o_s_araddr  = w_g_araddr;
                if (r_gnt_id == M_LSU) begin
                    o_m1_arready = i_s_arready;
                end else begin
                    o_m0_arready = i_s_arready;
                end
                if (w_ar_hs) begin
                    w_state_nxt = ST_R;
                end else if (!w_g_arvalid) begin
                    // Request withdrawn before the handshake: nothing was issued.
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_R: begin
                o_s_rready = w_g_rready;
                if (r_gnt_id == M_LSU) begin
                    o_m1_rvalid = i_s_rvalid;
                    o_m1_rdata  = i_s_rdata;
                    o_m1_rresp  = i_s_rresp;
                end else begin
                    o_m0_rvalid = i_s_rvalid;
                    o_m0_rdata  = i_s_rdata;
                    o_m0_rresp  = i_s_rresp;
                end
                if (i_s_rvalid && w_g_rready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
